// File: rtl/data_mem_pkg.sv
// Shared types and helpers for the data-memory responder: FSM states, bus widths, address-to-word mapping.
package data_mem_pkg;

    typedef enum logic [1:0] {
        IDLE,
        WAIT,
        ACCESS,
        RESP
    } state_t;

    localparam int WORD_W = 32;
    localparam int BE_W   = 4;

    // Word index relative to the window base; callers check the range separately.
    function automatic logic [WORD_W-1:0] addr_to_index(input logic [WORD_W-1:0] addr,
                                                        input logic [WORD_W-1:0] base);
        logic [WORD_W-1:0] off;
        off = addr - base;
        return {2'b00, off[WORD_W-1:2]};
    endfunction

endpackage

// File: rtl/data_mem_responder_if.sv
// Load/store request and response channels between the core's LSU (master) and the responder (slave).
interface data_mem_responder_if;
    import data_mem_pkg::*;

    logic              req_valid;
    logic              req_ready;
    logic              req_we;
    logic [WORD_W-1:0] req_addr;
    logic [WORD_W-1:0] req_wdata;
    logic [BE_W-1:0]   req_be;
    logic              rsp_valid;
    logic              rsp_ready;
    logic [WORD_W-1:0] rsp_rdata;
    logic              rsp_err;

    modport master (
        output req_valid, req_we, req_addr, req_wdata, req_be, rsp_ready,
        input  req_ready, rsp_valid, rsp_rdata, rsp_err
    );

    modport slave (
        input  req_valid, req_we, req_addr, req_wdata, req_be, rsp_ready,
        output req_ready, rsp_valid, rsp_rdata, rsp_err
    );

endinterface

// File: rtl/data_mem_ram.sv
// Single-port DEPTH x 32 RAM: byte-enabled synchronous write, registered read, one access per enabled cycle.
module data_mem_ram
    import data_mem_pkg::*;
#(
    parameter  int DEPTH = 64,
    localparam int IDX_W = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              en,
    input  logic              we,
    input  logic [BE_W-1:0]   be,
    input  logic [IDX_W-1:0]  idx,
    input  logic [WORD_W-1:0] wdata,
    output logic [WORD_W-1:0] rdata
);

    logic [WORD_W-1:0] mem [DEPTH];

    // Contents and read register are deliberately not reset.
    always_ff @(posedge clk) begin
        if (en) begin
            if (we) begin
                for (int i = 0; i < BE_W; i++) begin
                    if (be[i]) begin
                        mem[idx][8*i +: 8] <= wdata[8*i +: 8];
                    end
                end
            end else begin
                rdata <= mem[idx];
            end
        end
    end

endmodule

// File: rtl/data_mem_responder.sv
// Multi-cycle data-memory slave: response WAIT_CYCLES+2 cycles after the accept cycle, one transaction in flight.
// Holds the response stable while rsp_ready is low; req_ready is high only in IDLE.
module data_mem_responder
    import data_mem_pkg::*;
#(
    parameter int          DEPTH       = 64,
    parameter int          WAIT_CYCLES = 2,
    parameter logic [31:0] BASE_ADDR   = 32'h0000_0000
) (
    input  logic               clk,
    input  logic               reset,
    data_mem_responder_if.slave bus
);

    localparam int IDX_W = $clog2(DEPTH);

    state_t            state;
    state_t            state_nxt;
    logic [3:0]        wait_cnt;
    logic              hold_we;
    logic [WORD_W-1:0] hold_addr;
    logic [WORD_W-1:0] hold_wdata;
    logic [BE_W-1:0]   hold_be;
    logic              rsp_err_q;
    logic              rsp_load_q;
    logic              accept;
    logic [WORD_W:0]   base_diff;
    logic [WORD_W-1:0] word_off;
    logic              acc_err;
    logic              ram_en;
    logic [IDX_W-1:0]  ram_idx;
    logic [WORD_W-1:0] ram_rdata;

    assign accept    = bus.req_valid && (state == IDLE);
    // Borrow out of the widened subtraction flags addresses below the window.
    assign base_diff = {1'b0, hold_addr} - {1'b0, BASE_ADDR};
    assign word_off  = addr_to_index(hold_addr, BASE_ADDR);
    assign acc_err   = (hold_addr[1:0] != 2'b00) || base_diff[WORD_W] || (word_off >= 32'(DEPTH));
    assign ram_en    = (state == ACCESS) && !acc_err;
    assign ram_idx   = word_off[IDX_W-1:0];

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (accept) state_nxt = (WAIT_CYCLES == 0) ? ACCESS : WAIT;
            WAIT:    if (wait_cnt == 4'd0) state_nxt = ACCESS;
            ACCESS:  state_nxt = RESP;
            RESP:    if (bus.rsp_ready) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        bus.req_ready = (state == IDLE);
        bus.rsp_valid = (state == RESP);
        bus.rsp_err   = rsp_err_q;
        bus.rsp_rdata = rsp_load_q ? ram_rdata : '0;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wait_cnt   <= 4'd0;
            hold_we    <= 1'b0;
            hold_addr  <= '0;
            hold_wdata <= '0;
            hold_be    <= '0;
            rsp_err_q  <= 1'b0;
            rsp_load_q <= 1'b0;
        end else begin
            if (accept) begin
                hold_we    <= bus.req_we;
                hold_addr  <= bus.req_addr;
                hold_wdata <= bus.req_wdata;
                hold_be    <= bus.req_be;
                wait_cnt   <= (WAIT_CYCLES == 0) ? 4'd0 : 4'(WAIT_CYCLES - 1);
            end else if ((state == WAIT) && (wait_cnt != 4'd0)) begin
                wait_cnt <= wait_cnt - 4'd1;
            end

            // Response flags update only at ACCESS exit and clear on the handshake, so RESP outputs stay frozen.
            if (state == ACCESS) begin
                rsp_err_q  <= acc_err;
                rsp_load_q <= !hold_we && !acc_err;
            end else if ((state == RESP) && bus.rsp_ready) begin
                rsp_err_q  <= 1'b0;
                rsp_load_q <= 1'b0;
            end
        end
    end

    data_mem_ram #(
        .DEPTH(DEPTH)
    ) u_ram (
        .clk  (clk),
        .en   (ram_en),
        .we   (hold_we),
        .be   (hold_be),
        .idx  (ram_idx),
        .wdata(hold_wdata),
        .rdata(ram_rdata)
    );

endmodule

// File: tb/tb_data_mem_responder.sv
// Scoreboard bench: two responders (WAIT_CYCLES=2 at base 0, WAIT_CYCLES=0 at base 0x1000) driven with directed vectors.
module tb_data_mem_responder;

    typedef struct {
        logic [31:0] rdata;
        logic        err;
        int          acc_cyc;
        int          lat;
    } exp_t;

    typedef struct {
        logic        we;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [3:0]  be;
        logic [31:0] rd;
        logic        err;
    } vec_t;

    logic clk   = 1'b0;
    logic rst_n = 1'b1;
    int   cyc    = 0;
    int   checks = 0;
    int   passed = 0;
    exp_t q2[$];
    exp_t q0[$];

    data_mem_responder_if b2();
    data_mem_responder_if b0();

    data_mem_responder #(
        .DEPTH(64), .WAIT_CYCLES(2), .BASE_ADDR(32'h0000_0000)
    ) dut2 (
        .clk(clk), .reset(rst_n), .bus(b2.slave)
    );

    data_mem_responder #(
        .DEPTH(64), .WAIT_CYCLES(0), .BASE_ADDR(32'h0000_1000)
    ) dut0 (
        .clk(clk), .reset(rst_n), .bus(b0.slave)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check32(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    task automatic check1(input string name, input logic act, input logic exp);
        checks++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %b expected %b", name, act, exp);
    endtask

    task automatic note_fail(input string name);
        checks++;
        $display("FAIL %s: event not as required (bound expired or stray response)", name);
    endtask

    // Response monitor for the WAIT_CYCLES=2 responder, including hold-stability under backpressure.
    logic        prev2 = 1'b0;
    logic [31:0] snap_rd2;
    logic        snap_err2;
    always @(negedge clk) begin
        if (b2.rsp_valid) begin
            check1("dut2_req_ready_in_resp", b2.req_ready, 1'b0);
            if (!prev2) begin
                snap_rd2  = b2.rsp_rdata;
                snap_err2 = b2.rsp_err;
                if (q2.size() == 0) note_fail("dut2_unexpected_rsp");
                else check32("dut2_latency", cyc, q2[0].acc_cyc + q2[0].lat);
            end else begin
                check32("dut2_hold_rdata", b2.rsp_rdata, snap_rd2);
                check1("dut2_hold_err", b2.rsp_err, snap_err2);
            end
            if (b2.rsp_ready && q2.size() != 0) begin
                check32("dut2_rdata", b2.rsp_rdata, q2[0].rdata);
                check1("dut2_err", b2.rsp_err, q2[0].err);
                void'(q2.pop_front());
            end
        end
        prev2 = b2.rsp_valid;
    end

    logic prev0 = 1'b0;
    always @(negedge clk) begin
        if (b0.rsp_valid) begin
            if (!prev0) begin
                if (q0.size() == 0) note_fail("dut0_unexpected_rsp");
                else check32("dut0_latency", cyc, q0[0].acc_cyc + q0[0].lat);
            end
            if (b0.rsp_ready && q0.size() != 0) begin
                check32("dut0_rdata", b0.rsp_rdata, q0[0].rdata);
                check1("dut0_err", b0.rsp_err, q0[0].err);
                void'(q0.pop_front());
            end
        end
        prev0 = b0.rsp_valid;
    end

    task automatic req2(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                        input logic [3:0] be, input logic [31:0] exp_rd, input logic exp_err,
                        input bit push);
        int guard;
        guard = 0;
        @(posedge clk); #1;
        b2.req_valid = 1'b1;
        b2.req_we    = we;
        b2.req_addr  = addr;
        b2.req_wdata = wdata;
        b2.req_be    = be;
        @(negedge clk);
        while (b2.req_ready !== 1'b1 && guard < 100) begin
            @(negedge clk);
            guard++;
        end
        if (guard >= 100) note_fail("dut2_accept_timeout");
        else if (push) q2.push_back(exp_t'{exp_rd, exp_err, cyc, 4});
        @(posedge clk); #1;
        b2.req_valid = 1'b0;
    endtask

    task automatic wait_idle2();
        int guard;
        guard = 0;
        while (q2.size() != 0 && guard < 200) begin
            @(negedge clk);
            guard++;
        end
        if (guard >= 200) note_fail("dut2_rsp_timeout");
    endtask

    task automatic drive0(input vec_t v);
        b0.req_we    = v.we;
        b0.req_addr  = v.addr;
        b0.req_wdata = v.wdata;
        b0.req_be    = v.be;
    endtask

    vec_t v0[8] = '{
        '{1'b1, 32'h0000_1000, 32'hA5A5_A5A5, 4'hF, 32'h0,         1'b0},
        '{1'b1, 32'h0000_1004, 32'h1234_5678, 4'hF, 32'h0,         1'b0},
        '{1'b0, 32'h0000_1000, 32'h0,         4'h0, 32'hA5A5_A5A5, 1'b0},
        '{1'b0, 32'h0000_1004, 32'h0,         4'h0, 32'h1234_5678, 1'b0},
        '{1'b0, 32'h0000_0FFC, 32'h0,         4'h0, 32'h0,         1'b1},
        '{1'b1, 32'h0000_1100, 32'hFFFF_FFFF, 4'hF, 32'h0,         1'b1},
        '{1'b0, 32'h0000_1000, 32'h0,         4'h0, 32'hA5A5_A5A5, 1'b0},
        '{1'b1, 32'h0000_1001, 32'hFFFF_FFFF, 4'hF, 32'h0,         1'b1}
    };

    initial begin
        int acc0[8];
        int guard;
        b2.req_valid = 1'b0; b2.req_we = 1'b0; b2.req_addr = '0; b2.req_wdata = '0;
        b2.req_be = '0; b2.rsp_ready = 1'b1;
        b0.req_valid = 1'b0; b0.req_we = 1'b0; b0.req_addr = '0; b0.req_wdata = '0;
        b0.req_be = '0; b0.rsp_ready = 1'b1;

        #2 rst_n = 1'b0;
        #1;
        check1("reset_req_ready", b2.req_ready, 1'b1);
        check1("reset_rsp_valid", b2.rsp_valid, 1'b0);
        check32("reset_rsp_rdata", b2.rsp_rdata, 32'h0);
        check1("reset_rsp_err", b2.rsp_err, 1'b0);
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;

        // Round trip and byte-enable merge.
        req2(1'b1, 32'h10, 32'hDEAD_BEEF, 4'hF, 32'h0, 1'b0, 1'b1);         wait_idle2();
        req2(1'b0, 32'h10, 32'h0, 4'h0, 32'hDEAD_BEEF, 1'b0, 1'b1);         wait_idle2();
        req2(1'b1, 32'h20, 32'h1122_3344, 4'hF, 32'h0, 1'b0, 1'b1);         wait_idle2();
        req2(1'b1, 32'h20, 32'hAABB_CCDD, 4'b0101, 32'h0, 1'b0, 1'b1);      wait_idle2();
        req2(1'b0, 32'h20, 32'h0, 4'h0, 32'h11BB_33DD, 1'b0, 1'b1);         wait_idle2();
        req2(1'b1, 32'h20, 32'hFFFF_FFFF, 4'h0, 32'h0, 1'b0, 1'b1);         wait_idle2();
        req2(1'b0, 32'h20, 32'h0, 4'h0, 32'h11BB_33DD, 1'b0, 1'b1);         wait_idle2();

        // Misaligned and out-of-range accesses.
        req2(1'b0, 32'h22, 32'h0, 4'h0, 32'h0, 1'b1, 1'b1);                 wait_idle2();
        req2(1'b1, 32'h00, 32'h1234_5678, 4'hF, 32'h0, 1'b0, 1'b1);         wait_idle2();
        req2(1'b1, 32'h100, 32'hFFFF_FFFF, 4'hF, 32'h0, 1'b1, 1'b1);        wait_idle2();
        req2(1'b0, 32'h00, 32'h0, 4'h0, 32'h1234_5678, 1'b0, 1'b1);         wait_idle2();

        // Backpressure: response must stay frozen for 10 cycles.
        @(posedge clk); #1 b2.rsp_ready = 1'b0;
        req2(1'b0, 32'h10, 32'h0, 4'h0, 32'hDEAD_BEEF, 1'b0, 1'b1);
        guard = 0;
        while (b2.rsp_valid !== 1'b1 && guard < 50) begin
            @(negedge clk);
            guard++;
        end
        if (guard >= 50) note_fail("dut2_bp_rsp_timeout");
        repeat (10) @(negedge clk);
        @(posedge clk); #1 b2.rsp_ready = 1'b1;
        @(negedge clk);
        @(negedge clk);
        check1("dut2_idle_after_hs", b2.req_ready, 1'b1);
        check1("dut2_valid_fall", b2.rsp_valid, 1'b0);
        wait_idle2();

        // Reset one cycle after accepting a store: dropped, RAM untouched.
        req2(1'b1, 32'h30, 32'h0, 4'hF, 32'h0, 1'b0, 1'b1);                 wait_idle2();
        req2(1'b1, 32'h30, 32'hCAFE_F00D, 4'hF, 32'h0, 1'b0, 1'b0);
        @(posedge clk); #1 rst_n = 1'b0;
        #1;
        check1("midrst_req_ready", b2.req_ready, 1'b1);
        check1("midrst_rsp_valid", b2.rsp_valid, 1'b0);
        check32("midrst_rsp_rdata", b2.rsp_rdata, 32'h0);
        check1("midrst_rsp_err", b2.rsp_err, 1'b0);
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        repeat (12) @(negedge clk);
        req2(1'b0, 32'h30, 32'h0, 4'h0, 32'h0, 1'b0, 1'b1);                 wait_idle2();

        // Zero-wait responder, back-to-back with rsp_ready tied high.
        @(posedge clk); #1;
        b0.req_valid = 1'b1;
        drive0(v0[0]);
        for (int i = 0; i < 8; i++) begin
            guard = 0;
            @(negedge clk);
            while (b0.req_ready !== 1'b1 && guard < 20) begin
                @(negedge clk);
                guard++;
            end
            if (guard >= 20) begin
                note_fail("dut0_accept_timeout");
                acc0[i] = cyc;
            end else begin
                acc0[i] = cyc;
                q0.push_back(exp_t'{v0[i].rd, v0[i].err, cyc, 2});
                if (i > 0) check32("dut0_accept_spacing", acc0[i] - acc0[i-1], 32'd3);
            end
            @(posedge clk); #1;
            if (i < 7) drive0(v0[i+1]);
            else b0.req_valid = 1'b0;
        end
        guard = 0;
        while (q0.size() != 0 && guard < 50) begin
            @(negedge clk);
            guard++;
        end
        if (guard >= 50) note_fail("dut0_rsp_timeout");
        repeat (4) @(negedge clk);

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

    initial begin
        #300000;
        note_fail("watchdog");
        $display("%0d/%0d checks passed", passed, checks);
        $fatal(1, "watchdog expired");
    end

endmodule
